// File: rtl/cpu_control_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing,
// memory handshake with optional timeout. Optional counters under CPU_CTRL_PERF_EN.
module cpu_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_instr,
  input  logic        i_branch_taken,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_addr_sel,
  output logic        o_ir_load,
  output logic        o_alu_src_a,
  output logic        o_alu_src_b,
  output logic [1:0]  o_alu_op,
  output logic        o_alu_out_we,
  output logic        o_reg_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_pc_load,
  output logic        o_pc_src,
  output logic        o_halted,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [31:0] o_instret,
  output logic [31:0] o_wait_cycles
`endif
);

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;
  localparam logic [2:0] F3_WORD      = 3'b010;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_PASS_B = 2'd2;

  localparam logic [1:0] CAUSE_OPC  = 2'd1;
  localparam logic [1:0] CAUSE_F3   = 2'd2;
  localparam logic [1:0] CAUSE_TMO  = 2'd3;

  localparam logic [TIMEOUT_W-1:0] LP_LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_TRAP      = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [1:0]           r_trap_cause;
  logic [1:0]           w_cause_next;
  logic [TIMEOUT_W-1:0] r_wait_cnt;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_jump;
  logic       w_legal_opc;
  logic       w_timeout;
  logic       w_unused;

  assign w_opcode   = i_instr[6:0];
  assign w_funct3   = i_instr[14:12];
  assign w_is_load  = (w_opcode == OPC_LOAD);
  assign w_is_store = (w_opcode == OPC_STORE);
  assign w_is_jump  = (w_opcode == OPC_JAL) || (w_opcode == OPC_JALR);
  assign w_unused   = ^{i_instr[31:15], i_instr[11:7]};

  // Only reached-limit-without-ready traps; a ready on the limit cycle completes the access.
  assign w_timeout = (MEM_TIMEOUT != 32'd0) && (r_wait_cnt == LP_LIMIT) && !i_mem_ready;

  // Supported opcode set
  always_comb begin
    case (w_opcode)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: w_legal_opc = 1'b1;
      default:                                             w_legal_opc = 1'b0;
    endcase
  end

  // State, trap cause and wait counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_trap_cause <= 2'd0;
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_trap_cause <= w_cause_next;
      if (w_state_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (o_mem_req && !i_mem_ready) begin
        r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_next   = r_state;
    w_cause_next   = r_trap_cause;
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr_sel = 1'b0;
    o_ir_load      = 1'b0;
    o_alu_src_a    = 1'b0;
    o_alu_src_b    = 1'b0;
    o_alu_op       = ALU_ADD;
    o_alu_out_we   = 1'b0;
    o_reg_we       = 1'b0;
    o_wb_sel       = 2'd0;
    o_pc_load      = 1'b0;
    o_pc_src       = 1'b0;
    o_halted       = 1'b0;
    o_trap         = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_FETCH;
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_load    = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
          w_cause_next = CAUSE_TMO;
        end else begin
          w_state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (!w_legal_opc) begin
          w_state_next = S_TRAP;
          w_cause_next = CAUSE_OPC;
        end else if ((w_is_load || w_is_store) && (w_funct3 != F3_WORD)) begin
          w_state_next = S_TRAP;
          w_cause_next = CAUSE_F3;
        end else if (w_opcode == OPC_SYSTEM) begin
          w_state_next = S_HALT;
        end else if (w_opcode == OPC_MISC_MEM) begin
          o_pc_load    = 1'b1;
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        o_alu_out_we = 1'b1;
        w_state_next = S_WRITEBACK;
        case (w_opcode)
          OPC_LOAD, OPC_STORE: begin
            o_alu_src_b  = 1'b1;
            w_state_next = S_MEM;
          end
          OPC_OP:     o_alu_op = ALU_FUNCT;
          OPC_OP_IMM: begin
            o_alu_src_b = 1'b1;
            o_alu_op    = ALU_FUNCT;
          end
          OPC_LUI: begin
            o_alu_src_b = 1'b1;
            o_alu_op    = ALU_PASS_B;
          end
          OPC_AUIPC, OPC_JAL: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 1'b1;
          end
          OPC_JALR: o_alu_src_b = 1'b1;
          OPC_BRANCH: begin
            // Target is forwarded from the ALU in this same cycle when taken.
            o_alu_src_a  = 1'b1;
            o_alu_src_b  = 1'b1;
            o_pc_load    = 1'b1;
            o_pc_src     = i_branch_taken;
            w_state_next = S_FETCH;
          end
          default: begin
            w_state_next = S_TRAP;
            w_cause_next = CAUSE_OPC;
          end
        endcase
      end
      S_MEM: begin
        o_mem_req      = 1'b1;
        o_mem_addr_sel = 1'b1;
        o_mem_we       = w_is_store;
        if (i_mem_ready) begin
          o_pc_load    = w_is_store;
          w_state_next = w_is_store ? S_FETCH : S_WRITEBACK;
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
          w_cause_next = CAUSE_TMO;
        end else begin
          w_state_next = S_MEM;
        end
      end
      S_WRITEBACK: begin
        o_reg_we     = 1'b1;
        o_pc_load    = 1'b1;
        o_pc_src     = w_is_jump;
        w_state_next = S_FETCH;
        if (w_is_load) begin
          o_wb_sel = 2'd1;
        end else if (w_is_jump) begin
          o_wb_sel = 2'd2;
        end else begin
          o_wb_sel = 2'd0;
        end
      end
      S_HALT: o_halted = 1'b1;
      S_TRAP: o_trap   = 1'b1;
      default: begin
        w_state_next = S_TRAP;
        w_cause_next = CAUSE_OPC;
      end
    endcase
  end

  assign o_trap_cause = r_trap_cause;

`ifdef CPU_CTRL_PERF_EN
  logic [31:0] r_instret;
  logic [31:0] r_wait_cycles;

  // Retired-instruction and memory-stall counters, both free-running with wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret     <= 32'd0;
      r_wait_cycles <= 32'd0;
    end else begin
      if (o_pc_load) begin
        r_instret <= r_instret + 32'd1;
      end else begin
        r_instret <= r_instret;
      end
      if (o_mem_req && !i_mem_ready) begin
        r_wait_cycles <= r_wait_cycles + 32'd1;
      end else begin
        r_wait_cycles <= r_wait_cycles;
      end
    end
  end

  assign o_instret     = r_instret;
  assign o_wait_cycles = r_wait_cycles;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: per-instruction expected cycle traces built from
// instruction class and memory wait counts, replayed with random fill inputs.
module tb_cpu_control_fsm;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        taken, ready;
  logic        o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_load, o_alu_src_a, o_alu_src_b;
  logic [1:0]  o_alu_op;
  logic        o_alu_out_we, o_reg_we;
  logic [1:0]  o_wb_sel;
  logic        o_pc_load, o_pc_src, o_halted, o_trap;
  logic [1:0]  o_trap_cause;

  always #5 clk = ~clk;

  cpu_control_fsm #(.MEM_TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .i_instr(instr), .i_branch_taken(taken), .i_mem_ready(ready),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr_sel(o_mem_addr_sel),
    .o_ir_load(o_ir_load), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
    .o_alu_op(o_alu_op), .o_alu_out_we(o_alu_out_we), .o_reg_we(o_reg_we),
    .o_wb_sel(o_wb_sel), .o_pc_load(o_pc_load), .o_pc_src(o_pc_src),
    .o_halted(o_halted), .o_trap(o_trap), .o_trap_cause(o_trap_cause)
  );

  typedef struct packed {
    logic       mem_req, mem_we, mem_addr_sel, ir_load, alu_src_a, alu_src_b;
    logic [1:0] alu_op;
    logic       alu_out_we, reg_we;
    logic [1:0] wb_sel;
    logic       pc_load, pc_src, halted, trap;
    logic [1:0] trap_cause;
  } outs_t;

  typedef struct packed {
    logic [31:0] ins;
    logic        rdy;
    logic        tk;
    outs_t       exp;
  } step_t;

  step_t q[$];
  int    checks   = 0;
  int    failures = 0;
  int    stick_n  = 3;

  function automatic outs_t sample();
    sample = {o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_load, o_alu_src_a, o_alu_src_b,
              o_alu_op, o_alu_out_we, o_reg_we, o_wb_sel, o_pc_load, o_pc_src,
              o_halted, o_trap, o_trap_cause};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [31:0] ins, input logic rdy, input logic tk, input outs_t e);
    step_t s;
    s.ins = ins; s.rdy = rdy; s.tk = tk; s.exp = e;
    q.push_back(s);
  endtask

  task automatic push_idle();
    push(32'h0000_0013, rb(), rb(), '0);
  endtask

  task automatic push_sticky(input logic [31:0] ins, input logic is_trap, input logic [1:0] cause);
    outs_t e;
    for (int n = 0; n < stick_n; n++) begin
      e = '0;
      if (is_trap) begin
        e.trap = 1'b1;
        e.trap_cause = cause;
      end else begin
        e.halted = 1'b1;
      end
      push(ins, rb(), rb(), e);
    end
  endtask

  // One memory access: 'waits' cycles without ready, then ready (or trap if over the limit)
  task automatic push_access(input logic [31:0] ins, input int waits, input logic data,
                             input logic store, output bit dead);
    outs_t e;
    e = '0;
    e.mem_req = 1'b1; e.mem_addr_sel = data; e.mem_we = store;
    dead = 1'b0;
    if (waits > TO) begin
      for (int c = 0; c <= TO; c++) push(ins, 1'b0, rb(), e);
      push_sticky(ins, 1'b1, 2'd3);
      dead = 1'b1;
    end else begin
      for (int c = 0; c < waits; c++) push(ins, 1'b0, rb(), e);
      e.ir_load = !data;
      e.pc_load = store;
      push(ins, 1'b1, rb(), e);
    end
  endtask

  task automatic push_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic tk, output bit dead);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       ld, st, jmp;
    outs_t      e;
    opc = ins[6:0];
    f3  = ins[14:12];
    ld  = (opc == 7'h03);
    st  = (opc == 7'h23);
    jmp = (opc == 7'h6F) || (opc == 7'h67);
    push_access(ins, fw, 1'b0, 1'b0, dead);
    if (dead) return;
    e = '0;
    e.pc_load = (opc == 7'h0F);
    push(ins, rb(), rb(), e);
    if (!(opc inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73})) begin
      push_sticky(ins, 1'b1, 2'd1); dead = 1'b1; return;
    end
    if ((ld || st) && f3 != 3'b010) begin
      push_sticky(ins, 1'b1, 2'd2); dead = 1'b1; return;
    end
    if (opc == 7'h73) begin
      push_sticky(ins, 1'b0, 2'd0); dead = 1'b1; return;
    end
    if (opc == 7'h0F) return;
    e = '0;
    e.alu_out_we = 1'b1;
    case (opc)
      7'h03, 7'h23, 7'h67: e.alu_src_b = 1'b1;
      7'h33: e.alu_op = 2'd1;
      7'h13: begin e.alu_src_b = 1'b1; e.alu_op = 2'd1; end
      7'h37: begin e.alu_src_b = 1'b1; e.alu_op = 2'd2; end
      7'h17, 7'h6F: begin e.alu_src_a = 1'b1; e.alu_src_b = 1'b1; end
      7'h63: begin e.alu_src_a = 1'b1; e.alu_src_b = 1'b1; e.pc_load = 1'b1; e.pc_src = tk; end
      default: ;
    endcase
    push(ins, rb(), (opc == 7'h63) ? tk : rb(), e);
    if (opc == 7'h63) return;
    if (ld || st) begin
      push_access(ins, mw, 1'b1, st, dead);
      if (dead || st) return;
    end
    e = '0;
    e.reg_we = 1'b1; e.pc_load = 1'b1; e.pc_src = jmp;
    e.wb_sel = ld ? 2'd1 : (jmp ? 2'd2 : 2'd0);
    push(ins, rb(), rb(), e);
  endtask

  task automatic step(input step_t s, output outs_t a);
    instr = s.ins; ready = s.rdy; taken = s.tk;
    @(negedge clk);
    a = sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; taken = 1'b0; instr = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    push_idle();
  endtask

  task automatic test_reset();
    outs_t a;
    rst = 1'b1; ready = 1'b1; taken = 1'b1; instr = 32'h0000A103;
    #2;
    a = sample();
    checks++;
    if (a !== '0) begin
      failures++; $display("FAIL reset_outputs got=%05h want=%05h", a, 18'h0);
    end
    @(posedge clk);
    #1;
    do_reset();
  endtask

  task automatic test_addi();
    outs_t a; bit dead;
    push_instr(32'h00500093, 0, 0, 1'b0, dead);
    foreach (q[i]) begin
      step(q[i], a); checks++;
      if (a !== q[i].exp) begin failures++; $display("FAIL addi step=%0d got=%05h want=%05h", i, a, q[i].exp); end
    end
  endtask

  task automatic test_lw_wait();
    outs_t a; bit dead;
    q.delete();
    push_instr(32'h0000A103, 1, 3, 1'b0, dead);
    foreach (q[i]) begin
      step(q[i], a); checks++;
      if (a !== q[i].exp) begin failures++; $display("FAIL lw_wait step=%0d got=%05h want=%05h", i, a, q[i].exp); end
    end
  endtask

  task automatic test_store_sh();
    outs_t a; bit dead;
    q.delete();
    stick_n = 10;
    push_instr(32'h0020A023, 0, 2, 1'b0, dead);
    push_instr(32'h00209023, 0, 0, 1'b0, dead);
    stick_n = 3;
    foreach (q[i]) begin
      step(q[i], a); checks++;
      if (a !== q[i].exp) begin failures++; $display("FAIL store_sh step=%0d got=%05h want=%05h", i, a, q[i].exp); end
    end
  endtask

  task automatic test_branch();
    outs_t a; bit dead;
    do_reset();
    push_instr(32'h00208463, 0, 0, 1'b1, dead);
    push_instr(32'h00208463, 2, 0, 1'b0, dead);
    foreach (q[i]) begin
      step(q[i], a); checks++;
      if (a !== q[i].exp) begin failures++; $display("FAIL branch step=%0d got=%05h want=%05h", i, a, q[i].exp); end
    end
  endtask

  task automatic test_timeout();
    outs_t a; bit dead;
    q.delete();
    push_instr(32'h00500093, TO + 3, 0, 1'b0, dead);
    foreach (q[i]) begin
      step(q[i], a); checks++;
      if (a !== q[i].exp) begin failures++; $display("FAIL fetch_timeout step=%0d got=%05h want=%05h", i, a, q[i].exp); end
    end
    do_reset();
    push_instr(32'h00500093, TO, 0, 1'b0, dead);
    push_instr(32'h0000A103, 0, TO, 1'b0, dead);
    push_instr(32'h0000A103, 0, TO + 1, 1'b0, dead);
    foreach (q[i]) begin
      step(q[i], a); checks++;
      if (a !== q[i].exp) begin failures++; $display("FAIL limit_edge step=%0d got=%05h want=%05h", i, a, q[i].exp); end
    end
  endtask

  task automatic test_illegal_halt();
    outs_t a; bit dead;
    do_reset();
    push_instr(32'h0000007F, 0, 0, 1'b0, dead);
    foreach (q[i]) begin
      step(q[i], a); checks++;
      if (a !== q[i].exp) begin failures++; $display("FAIL illegal_opc step=%0d got=%05h want=%05h", i, a, q[i].exp); end
    end
    do_reset();
    push_instr(32'h00000073, 1, 0, 1'b0, dead);
    foreach (q[i]) begin
      step(q[i], a); checks++;
      if (a !== q[i].exp) begin failures++; $display("FAIL ecall step=%0d got=%05h want=%05h", i, a, q[i].exp); end
    end
  endtask

  task automatic test_reset_in_mem();
    outs_t a; bit dead; step_t s;
    do_reset();
    push_instr(32'h0000A103, 0, 3, 1'b0, dead);
    for (int i = 0; i < 5; i++) begin
      step(q[i], a); checks++;
      if (a !== q[i].exp) begin failures++; $display("FAIL mid_prefix step=%0d got=%05h want=%05h", i, a, q[i].exp); end
    end
    instr = 32'h0000A103; ready = 1'b0;
    #1;
    a = sample(); checks++;
    if (a.mem_req !== 1'b1 || a.mem_addr_sel !== 1'b1) begin
      failures++; $display("FAIL mid_in_mem got=%05h want mem_req=1 mem_addr_sel=1", a);
    end
    rst = 1'b1;
    #1;
    a = sample(); checks++;
    if (a !== '0) begin failures++; $display("FAIL mid_async_reset got=%05h want=%05h", a, 18'h0); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    push_idle();
    s.ins = 32'h0000A103; s.rdy = 1'b0; s.tk = 1'b0; s.exp = '0; s.exp.mem_req = 1'b1;
    q.push_back(s);
    foreach (q[i]) begin
      step(q[i], a); checks++;
      if (a !== q[i].exp) begin failures++; $display("FAIL after_reset step=%0d got=%05h want=%05h", i, a, q[i].exp); end
    end
  endtask

  task automatic test_random();
    logic [6:0]  opcs [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                               7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F, 7'h0B};
    logic [31:0] ins;
    int          fw, mw, r;
    outs_t       a;
    bit          dead;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 12)];
      if ((ins[6:0] == 7'h03 || ins[6:0] == 7'h23) && $urandom_range(0, 3) != 0) ins[14:12] = 3'b010;
      r  = $urandom_range(0, 9);
      fw = (r < 7) ? $urandom_range(0, 2) : ((r == 7) ? TO : ((r == 8) ? TO + 1 : 0));
      r  = $urandom_range(0, 9);
      mw = (r < 7) ? $urandom_range(0, 3) : ((r == 7) ? TO : ((r == 8) ? TO + 1 : 0));
      push_instr(ins, fw, mw, rb(), dead);
      foreach (q[i]) begin
        step(q[i], a); checks++;
        if (a !== q[i].exp) begin
          failures++; $display("FAIL random instr=%08h step=%0d got=%05h want=%05h", ins, i, a, q[i].exp);
        end
      end
      q.delete();
      if (dead) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_store_sh();
    test_branch();
    test_timeout();
    test_illegal_halt();
    test_reset_in_mem();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
